hyperram_wb_bridge: RTL

Upstream request stage for the hyperram controller. Accepts 32-bit Wishbone classic slave cycles from the Caravel management/user bus and converts each into exactly one hyperram transaction: a begin pulse with address, write flag, write mask and latencies. It then tracks the controller's busy/valid handshake and returns ack, error or read data. It also owns a latency/status CSR and a watchdog timeout, so a hung controller never stalls the bus.

---
 rtl/hyperram_pkg.sv | 35 +++
 rtl/hyperram_csr.sv | 51 +++++
 rtl/hyperram_wb_bridge.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/hyperram_pkg.sv
// Shared types and constants for the Wishbone-to-hyperram request bridge.
package hyperram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitStart,
    StWaitDone,
    StResp,
    StDrain
  } state_e;

  localparam int unsigned LatencyWidth  = 6;
  localparam int unsigned CsrWaitLsb    = 0;
  localparam int unsigned CsrDoneLsb    = 8;
  localparam int unsigned CsrTimeoutBit = 16;

  localparam logic [LatencyWidth-1:0] DefaultWaitLatency = 6'd6;
  localparam logic [LatencyWidth-1:0] DefaultDoneLatency = 6'd2;

  // CSR lives immediately above the memory window.
  localparam logic [31:0] DefaultCsrOffset = 32'h0080_0000;

  function automatic logic [31:0] csr_pack(input logic [LatencyWidth-1:0] wait_lat,
                                           input logic [LatencyWidth-1:0] done_lat,
                                           input logic                    timeout_flag);
    logic [31:0] img;
    img = '0;
    img[CsrWaitLsb +: LatencyWidth] = wait_lat;
    img[CsrDoneLsb +: LatencyWidth] = done_lat;
    img[CsrTimeoutBit]              = timeout_flag;
    return img;
  endfunction

endpackage

// File: rtl/hyperram_csr.sv
// Latency/status register: byte-masked writes, sticky write-1-to-clear timeout flag.
module hyperram_csr
  import hyperram_pkg::*;
#(
  parameter logic [LatencyWidth-1:0] DEFAULT_WAIT_LATENCY = DefaultWaitLatency,
  parameter logic [LatencyWidth-1:0] DEFAULT_DONE_LATENCY = DefaultDoneLatency
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [31:0]             wr_data,
  input  logic [3:0]              wr_sel,
  input  logic                    set_timeout,
  output logic [31:0]             rd_data,
  output logic [LatencyWidth-1:0] wait_latency,
  output logic [LatencyWidth-1:0] done_latency
);

  logic [LatencyWidth-1:0] wait_q, wait_d;
  logic [LatencyWidth-1:0] done_q, done_d;
  logic                    flag_q, flag_d;

  always_comb begin
    wait_d = wait_q;
    done_d = done_q;
    flag_d = flag_q;
    if (wr_en) begin
      if (wr_sel[0]) wait_d = wr_data[CsrWaitLsb +: LatencyWidth];
      if (wr_sel[1]) done_d = wr_data[CsrDoneLsb +: LatencyWidth];
      if (wr_sel[2] && wr_data[CsrTimeoutBit]) flag_d = 1'b0;
    end
    if (set_timeout) flag_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= DEFAULT_WAIT_LATENCY;
      done_q <= DEFAULT_DONE_LATENCY;
      flag_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      done_q <= done_d;
      flag_q <= flag_d;
    end
  end

  assign rd_data      = csr_pack(wait_q, done_q, flag_q);
  assign wait_latency = wait_q;
  assign done_latency = done_q;

endmodule

// File: rtl/hyperram_wb_bridge.sv
// Wishbone classic slave that turns each memory cycle into one hyperram transaction,
// with a latency/status CSR and a watchdog so a hung controller cannot stall the bus.
module hyperram_wb_bridge
  import hyperram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR            = 32'h3000_0000,
  parameter logic [31:0] MEM_BYTES            = DefaultCsrOffset,
  parameter int unsigned DEFAULT_WAIT_LATENCY = 6,
  parameter int unsigned DEFAULT_DONE_LATENCY = 2,
  parameter int unsigned TIMEOUT_CYCLES       = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [31:0] wbs_dat_o,
  output logic        hr_transaction_begin,
  output logic [31:0] hr_address,
  output logic        hr_write_enable,
  output logic [3:0]  hr_write_mask,
  output logic [31:0] hr_data_in,
  output logic [5:0]  hr_wait_latency,
  output logic [5:0]  hr_done_latency,
  input  logic        hr_busy,
  input  logic        hr_read_valid,
  input  logic [31:0] hr_read_data
);

  localparam logic [31:0] CsrAddr     = BASE_ADDR + MEM_BYTES;
  localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0] csr_rdata_q, csr_rdata_d;
  logic        we_q, we_d;
  logic [3:0]  mask_q, mask_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy_seen_q, busy_seen_d;
  logic        csr_ack_q, csr_ack_d, addr_err_q, addr_err_d;
  logic        req, mem_hit, csr_hit, csr_wr, cnt_expired, timeout_hit;
  logic [31:0] offset, csr_rd_data;

  // A request still held during its own ack/err cycle must not be decoded twice.
  assign req         = wbs_cyc_i & wbs_stb_i & ~csr_ack_q & ~addr_err_q;
  assign mem_hit     = (wbs_adr_i >= BASE_ADDR) && (wbs_adr_i < CsrAddr);
  assign csr_hit     = (wbs_adr_i == CsrAddr);
  assign csr_wr      = (state_q == StIdle) & req & csr_hit & wbs_we_i;
  assign offset      = wbs_adr_i - BASE_ADDR;
  assign cnt_expired = (cnt_q == TimeoutLast);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    we_d        = we_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    busy_seen_d = busy_seen_q;
    csr_ack_d   = 1'b0;
    addr_err_d  = 1'b0;
    csr_rdata_d = '0;
    timeout_hit = 1'b0;

    // Watchdog saturates; it also bounds DRAIN when an aborted request never saw busy.
    if (state_q inside {StWaitStart, StWaitDone, StDrain}) begin
      if (!cnt_expired) cnt_d = cnt_q + 8'd1;
      if (hr_busy) busy_seen_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (mem_hit) begin
            state_d = StIssue;
            addr_d  = {offset[31:2], 2'b00};
            we_d    = wbs_we_i;
            mask_d  = wbs_we_i ? ~wbs_sel_i : 4'hF;
            wdata_d = wbs_dat_i;
            rdata_d = '0;
          end else if (csr_hit) begin
            csr_ack_d = 1'b1;
            if (!wbs_we_i) csr_rdata_d = csr_rd_data;
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end
      StIssue: begin
        cnt_d       = '0;
        busy_seen_d = 1'b0;
        state_d     = wbs_cyc_i ? StWaitStart : StDrain;
      end
      StWaitStart: begin
        if (!wbs_cyc_i) begin
          state_d = StDrain;
        end else if (hr_busy) begin
          state_d = StWaitDone;
        end else if (cnt_expired) begin
          timeout_hit = 1'b1;
          state_d     = StDrain;
        end
      end
      StWaitDone: begin
        if (hr_read_valid) rdata_d = hr_read_data;
        if (!wbs_cyc_i) begin
          state_d = StDrain;
        end else if (!hr_busy) begin
          state_d = StResp;
        end else if (cnt_expired) begin
          timeout_hit = 1'b1;
          state_d     = StDrain;
        end
      end
      StResp:  state_d = StIdle;
      StDrain: if (!hr_busy && (busy_seen_q || cnt_expired)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      we_q        <= 1'b0;
      mask_q      <= '0;
      cnt_q       <= '0;
      busy_seen_q <= 1'b0;
      csr_ack_q   <= 1'b0;
      addr_err_q  <= 1'b0;
      csr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      we_q        <= we_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      busy_seen_q <= busy_seen_d;
      csr_ack_q   <= csr_ack_d;
      addr_err_q  <= addr_err_d;
      csr_rdata_q <= csr_rdata_d;
    end
  end

  hyperram_csr #(
    .DEFAULT_WAIT_LATENCY(6'(DEFAULT_WAIT_LATENCY)),
    .DEFAULT_DONE_LATENCY(6'(DEFAULT_DONE_LATENCY))
  ) u_csr (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (csr_wr),
    .wr_data     (wbs_dat_i),
    .wr_sel      (wbs_sel_i),
    .set_timeout (timeout_hit),
    .rd_data     (csr_rd_data),
    .wait_latency(hr_wait_latency),
    .done_latency(hr_done_latency)
  );

  assign hr_transaction_begin = (state_q == StIssue);
  assign hr_address           = addr_q;
  assign hr_write_enable      = we_q;
  assign hr_write_mask        = mask_q;
  assign hr_data_in           = wdata_q;
  assign wbs_ack_o            = (state_q == StResp) | csr_ack_q;
  assign wbs_err_o            = addr_err_q | timeout_hit;
  assign wbs_dat_o            = (state_q == StResp && !we_q) ? rdata_q : csr_rdata_q;

endmodule
